// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline constants and types for the D-stage stall decision.
// Tuse/Tnew encodings match the control unit's per-class tables.
package hazard_stall_unit_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned TIME_W = 2;

    localparam logic [TIME_W-1:0] TUSE_BRANCH     = 2'd0;
    localparam logic [TIME_W-1:0] TUSE_ALU        = 2'd1;
    localparam logic [TIME_W-1:0] TUSE_STORE_DATA = 2'd2;
    localparam logic [TIME_W-1:0] TUSE_NONE       = 2'd3;

    localparam logic [TIME_W-1:0] TNEW_NONE = 2'd0;
    localparam logic [TIME_W-1:0] TNEW_ALU  = 2'd1;
    localparam logic [TIME_W-1:0] TNEW_MF   = 2'd1;
    localparam logic [TIME_W-1:0] TNEW_LOAD = 2'd2;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    typedef struct packed {
        logic [REG_W-1:0]  dst;
        logic [TIME_W-1:0] tnew;
        logic              md_start;
        logic              md_is_div;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '0;

    // Advance an entry by one stage: result gets one cycle closer, MDU start is consumed.
    function automatic sb_entry_t sb_aged(input sb_entry_t x);
        sb_entry_t r;
        r      = SB_BUBBLE;
        r.dst  = x.dst;
        r.tnew = (x.tnew == '0) ? '0 : x.tnew - TIME_W'(1);
        return r;
    endfunction

    // A source is blocked when an in-flight producer needs longer than the consumer can wait.
    function automatic logic src_hazard(input logic [REG_W-1:0]  src,
                                        input logic [TIME_W-1:0] tuse,
                                        input sb_entry_t         e,
                                        input sb_entry_t         m);
        logic e_hit;
        logic m_hit;
        e_hit = (e.dst == src) && (e.tnew > tuse);
        m_hit = (m.dst == src) && (m.tnew > tuse);
        return (src != '0) && (tuse != TUSE_NONE) && (e_hit || m_hit);
    endfunction

endpackage

// File: rtl/hazard_stall_unit_md_busy_mirror.sv
// Shadow copy of the multiply/divide unit's busy counter, loaded when a
// mult/div leaves E and counted down to idle.
module hazard_stall_unit_md_busy_mirror
    import hazard_stall_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic load_is_div,
    output logic md_busy
);

    localparam int unsigned MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int unsigned CNT_BITS   = $clog2(MAX_CYCLES + 1);
    localparam int unsigned CNT_W      = (CNT_BITS > 4) ? CNT_BITS : 4;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A new start always reloads, even if a previous operation is still counting.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign md_busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_stall_unit.sv
// D-stage stall decision: shadow E/M scoreboard of destinations and Tnew,
// compared against the D instruction's Tuse, plus the MDU busy mirror.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    input  logic [1:0] D_tuse_rs,
    input  logic [1:0] D_tuse_rt,
    input  logic [4:0] D_dst,
    input  logic [1:0] D_tnew,
    input  logic       D_md_start,
    input  logic       D_md_is_div,
    input  logic       D_md_use,
    output logic       stall,
    output logic       md_busy
);

    sb_entry_t sb_e_q;
    sb_entry_t sb_e_d;
    sb_entry_t sb_m_q;
    sb_entry_t sb_m_d;

    logic haz_rs;
    logic haz_rt;
    logic haz_md;

    // A stalled D instruction is replaced by a bubble in E; M always takes the aged E entry.
    always_comb begin
        sb_e_d = SB_BUBBLE;
        sb_m_d = sb_aged(sb_e_q);
        if (!stall) begin
            sb_e_d.dst       = D_dst;
            sb_e_d.tnew      = D_tnew;
            sb_e_d.md_start  = D_md_start;
            sb_e_d.md_is_div = D_md_is_div;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sb_e_q <= SB_BUBBLE;
            sb_m_q <= SB_BUBBLE;
        end else begin
            sb_e_q <= sb_e_d;
            sb_m_q <= sb_m_d;
        end
    end

    hazard_stall_unit_md_busy_mirror #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_mirror (
        .clk         (clk),
        .reset       (reset),
        .load        (sb_e_q.md_start),
        .load_is_div (sb_e_q.md_is_div),
        .md_busy     (md_busy)
    );

    // An MDU start sitting in E has not loaded the counter yet, so it blocks MDU users too.
    always_comb begin
        haz_rs = src_hazard(D_rs, D_tuse_rs, sb_e_q, sb_m_q);
        haz_rt = src_hazard(D_rt, D_tuse_rt, sb_e_q, sb_m_q);
        haz_md = D_md_use & (md_busy | sb_e_q.md_start);
        stall  = haz_rs | haz_rt | haz_md;
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed scoreboard bench for hazard_stall_unit: each issued D vector
// queues its expected stall/md_busy, and a monitor checks on the falling edge.
module tb_hazard_stall_unit;

    logic       clk;
    logic       reset;
    logic [4:0] D_rs;
    logic [4:0] D_rt;
    logic [1:0] D_tuse_rs;
    logic [1:0] D_tuse_rt;
    logic [4:0] D_dst;
    logic [1:0] D_tnew;
    logic       D_md_start;
    logic       D_md_is_div;
    logic       D_md_use;
    logic       stall;
    logic       md_busy;

    typedef struct {
        string name;
        logic  stall;
        logic  busy;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    hazard_stall_unit dut (
        .clk         (clk),
        .reset       (reset),
        .D_rs        (D_rs),
        .D_rt        (D_rt),
        .D_tuse_rs   (D_tuse_rs),
        .D_tuse_rt   (D_tuse_rt),
        .D_dst       (D_dst),
        .D_tnew      (D_tnew),
        .D_md_start  (D_md_start),
        .D_md_is_div (D_md_is_div),
        .D_md_use    (D_md_use),
        .stall       (stall),
        .md_busy     (md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one D instruction for one cycle and queue what the pipeline must see.
    task automatic step(input string name, input logic rst,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic [1:0] trs, input logic [1:0] trt,
                        input logic [4:0] dst, input logic [1:0] tnew,
                        input logic st, input logic dv, input logic um,
                        input logic exp_stall, input logic exp_busy);
        exp_t e;
        @(posedge clk);
        #1;
        reset       = rst;
        D_rs        = rs;
        D_rt        = rt;
        D_tuse_rs   = trs;
        D_tuse_rt   = trt;
        D_dst       = dst;
        D_tnew      = tnew;
        D_md_start  = st;
        D_md_is_div = dv;
        D_md_use    = um;
        e.name  = name;
        e.stall = exp_stall;
        e.busy  = exp_busy;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if (stall !== e.stall) begin
                bad++;
                $display("FAIL %s stall: got=%0b want=%0b", e.name, stall, e.stall);
            end
            total++;
            if (md_busy !== e.busy) begin
                bad++;
                $display("FAIL %s md_busy: got=%0b want=%0b", e.name, md_busy, e.busy);
            end
        end
    end

    initial begin
        reset       = 1'b1;
        D_rs        = '0;
        D_rt        = '0;
        D_tuse_rs   = 2'd3;
        D_tuse_rt   = 2'd3;
        D_dst       = '0;
        D_tnew      = '0;
        D_md_start  = 1'b0;
        D_md_is_div = 1'b0;
        D_md_use    = 1'b0;
        @(posedge clk);

        step("reset_state",     0, 5'd8,  5'd8,  2'd0, 2'd0, 5'd0,  2'd0, 0, 0, 0, 0, 0);

        // lw -> dependent addu: one bubble, then M.tnew=1 is forwardable
        step("lw_8",            0, 5'd1,  5'd0,  2'd1, 2'd3, 5'd8,  2'd2, 0, 0, 0, 0, 0);
        step("addu_dep_stall",  0, 5'd8,  5'd1,  2'd1, 2'd1, 5'd9,  2'd1, 0, 0, 0, 1, 0);
        step("addu_dep_release",0, 5'd8,  5'd1,  2'd1, 2'd1, 5'd9,  2'd1, 0, 0, 0, 0, 0);

        // addu -> beq stalls once; addu -> tuse=1 consumer does not
        step("addu_8",          0, 5'd1,  5'd2,  2'd1, 2'd1, 5'd8,  2'd1, 0, 0, 0, 0, 0);
        step("beq_stall",       0, 5'd8,  5'd0,  2'd0, 2'd0, 5'd0,  2'd0, 0, 0, 0, 1, 0);
        step("beq_release",     0, 5'd8,  5'd0,  2'd0, 2'd0, 5'd0,  2'd0, 0, 0, 0, 0, 0);
        step("addu_8b",         0, 5'd1,  5'd2,  2'd1, 2'd1, 5'd8,  2'd1, 0, 0, 0, 0, 0);
        step("tuse_eq_tnew",    0, 5'd8,  5'd2,  2'd1, 2'd1, 5'd0,  2'd0, 0, 0, 0, 0, 0);

        // $0 is never a hazard
        step("prod_r0",         0, 5'd1,  5'd0,  2'd1, 2'd3, 5'd0,  2'd2, 0, 0, 0, 0, 0);
        step("cons_r0",         0, 5'd0,  5'd0,  2'd0, 2'd0, 5'd0,  2'd0, 0, 0, 0, 0, 0);

        // rt path: store data equal timing, then branch via M entry
        step("lw_10",           0, 5'd29, 5'd0,  2'd1, 2'd3, 5'd10, 2'd2, 0, 0, 0, 0, 0);
        step("sw_rt_eq",        0, 5'd29, 5'd10, 2'd1, 2'd2, 5'd0,  2'd0, 0, 0, 0, 0, 0);
        step("beq_rt_m_stall",  0, 5'd0,  5'd10, 2'd0, 2'd0, 5'd0,  2'd0, 0, 0, 0, 1, 0);
        step("beq_rt_release",  0, 5'd0,  5'd10, 2'd0, 2'd0, 5'd0,  2'd0, 0, 0, 0, 0, 0);

        // tuse=3 on both sources never stalls
        step("lw_12",           0, 5'd29, 5'd0,  2'd1, 2'd3, 5'd12, 2'd2, 0, 0, 0, 0, 0);
        step("tuse_none",       0, 5'd12, 5'd12, 2'd3, 2'd3, 5'd0,  2'd0, 0, 0, 0, 0, 0);

        // mult then mflo: stall in E-start cycle plus five busy cycles
        step("mult",            0, 5'd2,  5'd3,  2'd1, 2'd1, 5'd0,  2'd0, 1, 0, 1, 0, 0);
        step("mflo_e_start",    0, 5'd0,  5'd0,  2'd3, 2'd3, 5'd4,  2'd1, 0, 0, 1, 1, 0);
        for (int i = 0; i < 5; i++)
            step("mflo_busy",   0, 5'd0,  5'd0,  2'd3, 2'd3, 5'd4,  2'd1, 0, 0, 1, 1, 1);
        step("mflo_release",    0, 5'd0,  5'd0,  2'd3, 2'd3, 5'd4,  2'd1, 0, 0, 1, 0, 0);

        // div with unrelated addu traffic, then mfhi waits out the remaining count
        step("div",             0, 5'd2,  5'd3,  2'd1, 2'd1, 5'd0,  2'd0, 1, 1, 1, 0, 0);
        step("addu_div_e",      0, 5'd5,  5'd6,  2'd1, 2'd1, 5'd7,  2'd1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            step("addu_div_busy", 0, 5'd5, 5'd6, 2'd1, 2'd1, 5'd7,  2'd1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++)
            step("mfhi_stall",  0, 5'd0,  5'd0,  2'd3, 2'd3, 5'd4,  2'd1, 0, 0, 1, 1, 1);
        step("mfhi_release",    0, 5'd0,  5'd0,  2'd3, 2'd3, 5'd4,  2'd1, 0, 0, 1, 0, 0);

        // reset while the counter sits at 7 and a lw is in E
        step("div2",            0, 5'd2,  5'd3,  2'd1, 2'd1, 5'd0,  2'd0, 1, 1, 1, 0, 0);
        step("div2_addu",       0, 5'd5,  5'd6,  2'd1, 2'd1, 5'd7,  2'd1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++)
            step("div2_busy",   0, 5'd5,  5'd6,  2'd1, 2'd1, 5'd7,  2'd1, 0, 0, 0, 0, 1);
        step("lw_8_busy",       0, 5'd29, 5'd0,  2'd1, 2'd3, 5'd8,  2'd2, 0, 0, 0, 0, 1);
        step("pre_reset",       1, 5'd8,  5'd0,  2'd0, 2'd3, 5'd0,  2'd0, 0, 0, 0, 1, 1);
        step("post_reset",      0, 5'd8,  5'd0,  2'd0, 2'd3, 5'd0,  2'd0, 0, 0, 0, 0, 0);
        step("post_reset_md",   0, 5'd8,  5'd0,  2'd0, 2'd3, 5'd0,  2'd0, 0, 0, 1, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++)
            @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
